// File: rtl/tx_frame_arbiter.sv
// Arbitrates a register-read byte source and a two-byte ALU result source onto one TX FIFO
// write port. One-entry holding buffer per source, round-robin on ties, ALU frames unbroken.
module tx_frame_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ALU_WIDTH  = 2 * DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] reg_data_i,
  input  logic                  reg_vld_i,
  output logic                  reg_ack_o,
  input  logic [ALU_WIDTH-1:0]  alu_data_i,
  input  logic                  alu_vld_i,
  output logic                  alu_ack_o,
  input  logic                  fifo_full_i,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  wr_inc_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StSendReg   = 2'd1,
    StSendAluLo = 2'd2,
    StSendAluHi = 2'd3
  } state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] reg_buf_q;
  logic [ALU_WIDTH-1:0]  alu_buf_q;
  logic                  reg_pend_q;
  logic                  alu_pend_q;
  logic                  last_alu_q;  // 1: ALU was granted most recently

  // Acks are held low during reset so nothing is captured into a buffer being cleared.
  assign reg_ack_o = rst_ni & reg_vld_i & ~reg_pend_q;
  assign alu_ack_o = rst_ni & alu_vld_i & ~alu_pend_q;
  assign busy_o    = reg_pend_q | alu_pend_q | (state_q != StIdle);

  always_comb begin
    wr_inc_o  = 1'b0;
    wr_data_o = '0;
    unique case (state_q)
      StSendReg: begin
        if (!fifo_full_i) begin
          wr_inc_o  = 1'b1;
          wr_data_o = reg_buf_q;
        end
      end
      StSendAluLo: begin
        if (!fifo_full_i) begin
          wr_inc_o  = 1'b1;
          wr_data_o = alu_buf_q[DATA_WIDTH-1:0];
        end
      end
      StSendAluHi: begin
        if (!fifo_full_i) begin
          wr_inc_o  = 1'b1;
          wr_data_o = alu_buf_q[ALU_WIDTH-1:DATA_WIDTH];
        end
      end
      default: begin
        wr_inc_o  = 1'b0;
        wr_data_o = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      reg_buf_q  <= '0;
      alu_buf_q  <= '0;
      reg_pend_q <= 1'b0;
      alu_pend_q <= 1'b0;
      last_alu_q <= 1'b1;
    end else begin
      if (reg_ack_o) begin
        reg_buf_q  <= reg_data_i;
        reg_pend_q <= 1'b1;
      end
      if (alu_ack_o) begin
        alu_buf_q  <= alu_data_i;
        alu_pend_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (reg_pend_q && (!alu_pend_q || last_alu_q)) begin
            state_q    <= StSendReg;
            last_alu_q <= 1'b0;
          end else if (alu_pend_q) begin
            state_q    <= StSendAluLo;
            last_alu_q <= 1'b1;
          end
        end
        StSendReg: begin
          if (!fifo_full_i) begin
            reg_pend_q <= 1'b0;
            state_q    <= StIdle;
          end
        end
        StSendAluLo: begin
          if (!fifo_full_i) begin
            state_q <= StSendAluHi;
          end
        end
        StSendAluHi: begin
          if (!fifo_full_i) begin
            alu_pend_q <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed bench for tx_frame_arbiter: expected FIFO bytes are queued as requests are driven
// and checked in order by a monitor on every write strobe.
module tb_tx_frame_arbiter;

  logic        clk;
  logic        rst_n;
  logic [7:0]  reg_data;
  logic        reg_vld;
  logic        reg_ack;
  logic [15:0] alu_data;
  logic        alu_vld;
  logic        alu_ack;
  logic        fifo_full;
  logic [7:0]  wr_data;
  logic        wr_inc;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  tx_frame_arbiter #(
    .DATA_WIDTH(8),
    .ALU_WIDTH (16)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .reg_data_i (reg_data),
    .reg_vld_i  (reg_vld),
    .reg_ack_o  (reg_ack),
    .alu_data_i (alu_data),
    .alu_vld_i  (alu_vld),
    .alu_ack_o  (alu_ack),
    .fifo_full_i(fifo_full),
    .wr_data_o  (wr_data),
    .wr_inc_o   (wr_inc),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    @(negedge clk);
    for (int n = 0; n < 40 && busy; n++) @(negedge clk);
    check("drain_timeout", 32'(busy), 32'd0);
    tick();
  endtask

  // Scoreboard monitor plus per-cycle output invariants.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      check("wr_while_full", 32'(wr_inc & fifo_full), 32'd0);
      if (!wr_inc) begin
        check("wr_data_idle_zero", 32'(wr_data), 32'd0);
      end else begin
        check("write_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_data", 32'(wr_data), 32'(e));
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    reg_vld   = 1'b1;
    alu_vld   = 1'b1;
    reg_data  = 8'h5a;
    alu_data  = 16'h0001;
    fifo_full = 1'b0;

    // Reset state with requests asserted
    @(negedge clk);
    check("rst_reg_ack", 32'(reg_ack), 32'd0);
    check("rst_alu_ack", 32'(alu_ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_inc", 32'(wr_inc), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reg_vld = 1'b0;
    alu_vld = 1'b0;
    rst_n   = 1'b1;
    tick();

    // Single REG byte, latency
    reg_vld  = 1'b1;
    reg_data = 8'h5a;
    exp_q.push_back(8'h5a);
    @(negedge clk);
    check("reg_ack_c0", 32'(reg_ack), 32'd1);
    check("busy_c0", 32'(busy), 32'd0);
    tick();
    reg_vld = 1'b0;
    @(negedge clk);
    check("busy_c1", 32'(busy), 32'd1);
    check("wr_inc_c1", 32'(wr_inc), 32'd0);
    tick();
    @(negedge clk);
    check("wr_inc_c2", 32'(wr_inc), 32'd1);
    tick();
    @(negedge clk);
    check("busy_c3", 32'(busy), 32'd0);
    tick();

    // ALU frame, low byte first on consecutive cycles
    alu_vld  = 1'b1;
    alu_data = 16'h1234;
    exp_q.push_back(8'h34);
    exp_q.push_back(8'h12);
    @(negedge clk);
    check("alu_ack_c0", 32'(alu_ack), 32'd1);
    tick();
    alu_vld = 1'b0;
    @(negedge clk);
    check("alu_ack_c1", 32'(alu_ack), 32'd0);
    check("alu_wr_inc_c1", 32'(wr_inc), 32'd0);
    tick();
    @(negedge clk);
    check("alu_lo_c2", 32'(wr_inc), 32'd1);
    tick();
    @(negedge clk);
    check("alu_hi_c3", 32'(wr_inc), 32'd1);
    tick();
    @(negedge clk);
    check("alu_idle_c4", 32'(wr_inc | busy), 32'd0);
    tick();

    // Tie after reset: REG wins
    reg_vld  = 1'b1;
    reg_data = 8'haa;
    alu_vld  = 1'b1;
    alu_data = 16'hbeef;
    exp_q.push_back(8'haa);
    exp_q.push_back(8'hef);
    exp_q.push_back(8'hbe);
    @(negedge clk);
    check("tie1_reg_ack", 32'(reg_ack), 32'd1);
    check("tie1_alu_ack", 32'(alu_ack), 32'd1);
    tick();
    reg_vld = 1'b0;
    alu_vld = 1'b0;
    drain();

    // Lone REG byte leaves REG as last grant
    reg_vld  = 1'b1;
    reg_data = 8'h33;
    exp_q.push_back(8'h33);
    @(negedge clk);
    check("lone_reg_ack", 32'(reg_ack), 32'd1);
    tick();
    reg_vld = 1'b0;
    drain();

    // Tie again: ALU wins
    reg_vld  = 1'b1;
    reg_data = 8'h44;
    alu_vld  = 1'b1;
    alu_data = 16'h5566;
    exp_q.push_back(8'h66);
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h44);
    @(negedge clk);
    check("tie2_acks", 32'({reg_ack, alu_ack}), 32'd3);
    tick();
    reg_vld = 1'b0;
    alu_vld = 1'b0;
    drain();

    // Stall during the high byte, REG arrives meanwhile
    alu_vld  = 1'b1;
    alu_data = 16'h00ff;
    exp_q.push_back(8'hff);
    exp_q.push_back(8'h00);
    @(negedge clk);
    check("stall_alu_ack", 32'(alu_ack), 32'd1);
    tick();
    alu_vld = 1'b0;
    tick();
    @(negedge clk);
    check("stall_lo_wr", 32'(wr_inc), 32'd1);
    tick();
    fifo_full = 1'b1;
    reg_vld   = 1'b1;
    reg_data  = 8'h11;
    exp_q.push_back(8'h11);
    @(negedge clk);
    check("stall_reg_ack", 32'(reg_ack), 32'd1);
    check("stall_wr_c3", 32'(wr_inc), 32'd0);
    tick();
    reg_vld = 1'b0;
    @(negedge clk);
    check("stall_wr_c4", 32'(wr_inc), 32'd0);
    tick();
    @(negedge clk);
    check("stall_wr_c5", 32'(wr_inc), 32'd0);
    tick();
    fifo_full = 1'b0;
    @(negedge clk);
    check("stall_hi_wr_c6", 32'(wr_inc), 32'd1);
    tick();
    @(negedge clk);
    check("stall_gap_c7", 32'(wr_inc), 32'd0);
    tick();
    @(negedge clk);
    check("stall_reg_wr_c8", 32'(wr_inc), 32'd1);
    drain();

    // Reset while stalled in the high byte
    alu_vld  = 1'b1;
    alu_data = 16'hcafe;
    exp_q.push_back(8'hfe);
    @(negedge clk);
    check("rstmid_alu_ack", 32'(alu_ack), 32'd1);
    tick();
    alu_vld = 1'b0;
    tick();
    @(negedge clk);
    check("rstmid_lo_wr", 32'(wr_inc), 32'd1);
    tick();
    fifo_full = 1'b1;
    @(negedge clk);
    check("rstmid_stalled", 32'({wr_inc, busy}), 32'd1);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_wr", 32'({wr_inc, wr_data}), 32'd0);
    tick();
    tick();
    rst_n     = 1'b1;
    fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_quiet", 32'({wr_inc, busy}), 32'd0);
      tick();
    end
    reg_vld  = 1'b1;
    reg_data = 8'h77;
    alu_vld  = 1'b1;
    alu_data = 16'h9988;
    exp_q.push_back(8'h77);
    exp_q.push_back(8'h88);
    exp_q.push_back(8'h99);
    @(negedge clk);
    check("post_rst_acks", 32'({reg_ack, alu_ack}), 32'd3);
    tick();
    reg_vld = 1'b0;
    alu_vld = 1'b0;
    drain();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
